mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath. It sits in the execute stage beside the ALU and consumes the two register-file read operands. It performs MULT, MULTU, DIV and DIVU over a fixed number of cycles and holds the results in architectural HI/LO registers for MFHI/MFLO. Control stalls the PC while `busy` is high.

---
 rtl/mult_div_unit_pkg.sv | 29 ++
 rtl/mult_div_unit_sign_fix.sv | 20 ++
 rtl/mult_div_unit.sv | 170 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the MIPS multiply/divide unit: op encodings, funct codes
// that the control path decodes into them, and the unit's FSM states.
package mult_div_unit_pkg;

    localparam int MDU_N = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MTHI  = 6'd17;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MTLO  = 6'd19;
    localparam logic [5:0] FUNCT_MULT  = 6'd24;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_DIV   = 6'd26;
    localparam logic [5:0] FUNCT_DIVU  = 6'd27;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FIXUP = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of product, quotient and remainder.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    // Negate when requested, otherwise pass through
    always_comb begin
        if (neg) begin
            y = ~a + {{(W-1){1'b0}}, 1'b1};
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Signed ops run on magnitudes; signs are reapplied in FIXUP.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int N = MDU_N
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         hi_wen,
    input  logic         lo_wen,
    input  logic [N-1:0] wd,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N);

    mdu_state_e     state_r, state_s;
    mdu_op_e        op_r, op_in_s;
    logic [CW-1:0]  cnt_r;
    logic [N-1:0]   opd_r, ina_r, hi_r, lo_r;
    logic [2*N-1:0] acc_r, acc_step_s, prod_fix_s;
    logic           neg_res_r, neg_rem_r, dbz_r;
    logic           busy_r, done_r, dbz_out_r;
    logic           in_signed_s, in_div_s, r_div_s;
    logic [N-1:0]   mag_a_s, mag_b_s, quo_fix_s, rem_fix_s;
    logic [N:0]     mul_sum_s, rem_sh_s, div_diff_s;

    assign op_in_s     = mdu_op_e'(op);
    assign in_signed_s = (op_in_s == MDU_MULT) || (op_in_s == MDU_DIV);
    assign in_div_s    = (op_in_s == MDU_DIV) || (op_in_s == MDU_DIVU);
    assign r_div_s     = (op_r == MDU_DIV) || (op_r == MDU_DIVU);

    mdu_sign_fix #(.W(N)) u_mag_a (.a(inA), .neg(in_signed_s & inA[N-1]), .y(mag_a_s));
    mdu_sign_fix #(.W(N)) u_mag_b (.a(inB), .neg(in_signed_s & inB[N-1]), .y(mag_b_s));
    mdu_sign_fix #(.W(2*N)) u_fix_prod (.a(acc_r), .neg(neg_res_r), .y(prod_fix_s));
    mdu_sign_fix #(.W(N)) u_fix_quo (.a(acc_r[N-1:0]), .neg(neg_res_r), .y(quo_fix_s));
    mdu_sign_fix #(.W(N)) u_fix_rem (.a(acc_r[2*N-1:N]), .neg(neg_rem_r), .y(rem_fix_s));

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*N-1:N]} + (acc_r[0] ? {1'b0, opd_r} : {(N+1){1'b0}});
        rem_sh_s   = acc_r[2*N-1:N-1];
        div_diff_s = rem_sh_s - {1'b0, opd_r};
        if (r_div_s) begin
            if (!div_diff_s[N]) begin
                acc_step_s = {div_diff_s[N-1:0], acc_r[N-2:0], 1'b1};
            end else begin
                acc_step_s = {rem_sh_s[N-1:0], acc_r[N-2:0], 1'b0};
            end
        end else begin
            acc_step_s = {mul_sum_s, acc_r[N-1:1]};
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CW'(N-1)) begin
                    state_s = FIXUP;
                end else begin
                    state_s = RUN;
                end
            end
            FIXUP:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, HI/LO and registered status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r     <= {CW{1'b0}};
            op_r      <= MDU_MULT;
            opd_r     <= {N{1'b0}};
            ina_r     <= {N{1'b0}};
            acc_r     <= {(2*N){1'b0}};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dbz_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_out_r <= 1'b0;
            hi_r      <= {N{1'b0}};
            lo_r      <= {N{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r    <= 1'b0;
                    dbz_out_r <= 1'b0;
                    if (start) begin
                        // Divide keeps the dividend in the accumulator, multiply the multiplier
                        cnt_r     <= {CW{1'b0}};
                        op_r      <= op_in_s;
                        opd_r     <= in_div_s ? mag_b_s : mag_a_s;
                        acc_r     <= {{N{1'b0}}, (in_div_s ? mag_a_s : mag_b_s)};
                        ina_r     <= inA;
                        neg_res_r <= in_signed_s & (inA[N-1] ^ inB[N-1]);
                        neg_rem_r <= (op_in_s == MDU_DIV) & inA[N-1];
                        dbz_r     <= in_div_s & (inB == {N{1'b0}});
                        busy_r    <= 1'b1;
                    end else begin
                        if (hi_wen) begin
                            hi_r <= wd;
                        end
                        if (lo_wen) begin
                            lo_r <= wd;
                        end
                    end
                end
                RUN: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
                FIXUP: begin
                    busy_r    <= 1'b0;
                    done_r    <= 1'b1;
                    dbz_out_r <= dbz_r;
                    if (dbz_r) begin
                        lo_r <= {N{1'b1}};
                        hi_r <= ina_r;
                    end else if (r_div_s) begin
                        lo_r <= quo_fix_s;
                        hi_r <= rem_fix_s;
                    end else begin
                        lo_r <= prod_fix_s[N-1:0];
                        hi_r <= prod_fix_s[2*N-1:N];
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_out_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: reset, MULT/MULTU/DIV/DIVU,
// divide by zero, MTHI/MTLO and start/write hazards, back-to-back operation.
module tb_mult_div_unit;

    logic        clock, reset, start, hi_wen, lo_wen;
    logic [1:0]  op;
    logic [31:0] inA, inB, wd, hi, lo;
    logic        busy, done, div_by_zero;

    int tests_run = 0;
    int tests_failed = 0;

    mult_div_unit #(.N(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .inA(inA), .inB(inB), .hi_wen(hi_wen), .lo_wen(lo_wen), .wd(wd),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Runs one op and observes 75 edges after acceptance; an optional poke at edge poke_k
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int poke_k, input bit poke_start, input bit poke_hi,
                         input logic [1:0] po, input logic [31:0] pa, input logic [31:0] pb,
                         input bit lo_with_start,
                         output int ndone, output int first_lat, output int last_lat,
                         output int ndbz, output int nstray, output bit busy_ok,
                         output logic [31:0] lo_e0, output logic [31:0] hi_poke);
        ndone = 0; first_lat = 0; last_lat = 0; ndbz = 0; nstray = 0; busy_ok = 1'b1;
        hi_poke = 32'h0;
        @(negedge clock);
        op = o; inA = a; inB = b; start = 1'b1;
        lo_wen = lo_with_start; wd = 32'h0000_0099;
        @(posedge clock);
        #1 lo_e0 = lo;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clock);
            start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
            op = ~o; inA = ~a; inB = b ^ 32'h5A5A_5A5A;
            if (k == poke_k) begin
                if (poke_start) begin
                    start = 1'b1; op = po; inA = pa; inB = pb;
                end
                if (poke_hi) begin
                    hi_wen = 1'b1; wd = 32'h0000_00AA;
                end
            end
            @(posedge clock);
            #1;
            if (k == poke_k) hi_poke = hi;
            if (done === 1'b1) begin
                ndone++;
                if (first_lat == 0) first_lat = k;
                last_lat = k;
            end
            if (div_by_zero === 1'b1) begin
                if (done === 1'b1) ndbz++;
                else nstray++;
            end
            if (first_lat == 0 && busy !== 1'b1) busy_ok = 1'b0;
            if (k == first_lat && busy !== 1'b0) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (div_by_zero !== 1'b0) begin tests_failed++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL reset_hi: got %h expected 0", hi); end
        tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("FAIL reset_lo: got %h expected 0", lo); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_mt_writes;
        @(negedge clock); lo_wen = 1'b1; wd = 32'h0000_0055;
        @(posedge clock); #1;
        tests_run++; if (lo !== 32'h0000_0055) begin tests_failed++; $display("FAIL mtlo_idle: got %h expected 00000055", lo); end
        tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL mtlo_hi_hold: got %h expected 0", hi); end
        @(negedge clock); hi_wen = 1'b1; lo_wen = 1'b1; wd = 32'h0000_0077;
        @(posedge clock); #1;
        tests_run++; if (hi !== 32'h0000_0077) begin tests_failed++; $display("FAIL mt_both_hi: got %h expected 00000077", hi); end
        tests_run++; if (lo !== 32'h0000_0077) begin tests_failed++; $display("FAIL mt_both_lo: got %h expected 00000077", lo); end
        @(negedge clock); hi_wen = 1'b0; lo_wen = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        int nd, fl, ll, nz, ns; bit bok; logic [31:0] l0, hp;
        @(negedge clock); op = 2'b01; inA = 32'd7; inB = 32'd9; start = 1'b1;
        @(posedge clock);
        @(negedge clock); start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        tests_run++; if (hi !== 32'h0) begin tests_failed++; $display("FAIL midreset_hi: got %h expected 0", hi); end
        tests_run++; if (lo !== 32'h0) begin tests_failed++; $display("FAIL midreset_lo: got %h expected 0", lo); end
        @(negedge clock); reset = 1'b0;
        do_op(2'b01, 32'd3, 32'd5, 0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, nd, fl, ll, nz, ns, bok, l0, hp);
        tests_run++; if (nd !== 1) begin tests_failed++; $display("FAIL postreset_ndone: got %0d expected 1", nd); end
        tests_run++; if (fl !== 33) begin tests_failed++; $display("FAIL postreset_latency: got %0d expected 33", fl); end
        tests_run++; if (bok !== 1'b1) begin tests_failed++; $display("FAIL postreset_busy: got %b expected 1", bok); end
        tests_run++; if (lo !== 32'd15) begin tests_failed++; $display("FAIL postreset_lo: got %h expected 0000000f", lo); end
        tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL postreset_hi: got %h expected 0", hi); end
    endtask

    task automatic test_arith;
        int nd, fl, ll, nz, ns; bit bok; logic [31:0] l0, hp;
        logic [1:0]  vop [6] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [31:0] va  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'd7};
        logic [31:0] vb  [6] = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFE};
        logic [31:0] ehi [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'd2, 32'd1};
        logic [31:0] elo [6] = '{32'hFFFF_FFFA, 32'h0000_0001, 32'hFFFF_FFFD, 32'h8000_0000, 32'd14, 32'hFFFF_FFFD};
        for (int i = 0; i < 6; i++) begin
            do_op(vop[i], va[i], vb[i], 0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, nd, fl, ll, nz, ns, bok, l0, hp);
            tests_run++; if (hi !== ehi[i]) begin tests_failed++; $display("FAIL arith%0d_hi: got %h expected %h", i, hi, ehi[i]); end
            tests_run++; if (lo !== elo[i]) begin tests_failed++; $display("FAIL arith%0d_lo: got %h expected %h", i, lo, elo[i]); end
            tests_run++; if (nd !== 1 || fl !== 33) begin tests_failed++; $display("FAIL arith%0d_done: got %0d pulses at %0d expected 1 at 33", i, nd, fl); end
            tests_run++; if (nz !== 0 || ns !== 0) begin tests_failed++; $display("FAIL arith%0d_dbz: got %0d/%0d expected 0/0", i, nz, ns); end
        end
    endtask

    task automatic test_div_by_zero;
        int nd, fl, ll, nz, ns; bit bok; logic [31:0] l0, hp;
        logic [1:0]  vop [2] = '{2'b11, 2'b10};
        logic [31:0] va  [2] = '{32'h0000_1234, 32'hFFFF_FFF0};
        for (int i = 0; i < 2; i++) begin
            do_op(vop[i], va[i], 32'h0, 0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, nd, fl, ll, nz, ns, bok, l0, hp);
            tests_run++; if (lo !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL dbz%0d_lo: got %h expected ffffffff", i, lo); end
            tests_run++; if (hi !== va[i]) begin tests_failed++; $display("FAIL dbz%0d_hi: got %h expected %h", i, hi, va[i]); end
            tests_run++; if (nd !== 1 || fl !== 33) begin tests_failed++; $display("FAIL dbz%0d_done: got %0d pulses at %0d expected 1 at 33", i, nd, fl); end
            tests_run++; if (nz !== 1 || ns !== 0) begin tests_failed++; $display("FAIL dbz%0d_flag: got %0d with done, %0d stray, expected 1 and 0", i, nz, ns); end
        end
    endtask

    task automatic test_hazards;
        int nd, fl, ll, nz, ns; bit bok; logic [31:0] l0, hp;
        @(negedge clock); hi_wen = 1'b1; wd = 32'h0000_0033;
        @(negedge clock); hi_wen = 1'b0;
        do_op(2'b01, 32'd3, 32'd5, 5, 1'b1, 1'b1, 2'b01, 32'd9, 32'd9, 1'b0, nd, fl, ll, nz, ns, bok, l0, hp);
        tests_run++; if (hp !== 32'h0000_0033) begin tests_failed++; $display("FAIL mthi_busy_hold: got %h expected 00000033", hp); end
        tests_run++; if (nd !== 1) begin tests_failed++; $display("FAIL start_busy_ignored: got %0d done pulses expected 1", nd); end
        tests_run++; if (lo !== 32'd15) begin tests_failed++; $display("FAIL hazard_lo: got %h expected 0000000f", lo); end
        tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL hazard_hi: got %h expected 0", hi); end
        @(negedge clock); lo_wen = 1'b1; wd = 32'h0000_0077;
        @(negedge clock); lo_wen = 1'b0;
        do_op(2'b01, 32'd2, 32'd3, 0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, nd, fl, ll, nz, ns, bok, l0, hp);
        tests_run++; if (l0 !== 32'h0000_0077) begin tests_failed++; $display("FAIL start_wins_e0: got %h expected 00000077", l0); end
        tests_run++; if (lo !== 32'd6) begin tests_failed++; $display("FAIL start_wins_lo: got %h expected 00000006", lo); end
    endtask

    task automatic test_back_to_back;
        int nd, fl, ll, nz, ns; bit bok; logic [31:0] l0, hp;
        do_op(2'b01, 32'd3, 32'd5, 34, 1'b1, 1'b0, 2'b01, 32'd6, 32'd7, 1'b0, nd, fl, ll, nz, ns, bok, l0, hp);
        tests_run++; if (nd !== 2) begin tests_failed++; $display("FAIL b2b_ndone: got %0d expected 2", nd); end
        tests_run++; if (fl !== 33) begin tests_failed++; $display("FAIL b2b_first: got %0d expected 33", fl); end
        tests_run++; if (ll !== 67) begin tests_failed++; $display("FAIL b2b_second: got %0d expected 67", ll); end
        tests_run++; if (lo !== 32'd42) begin tests_failed++; $display("FAIL b2b_lo: got %h expected 0000002a", lo); end
        tests_run++; if (hi !== 32'd0) begin tests_failed++; $display("FAIL b2b_hi: got %h expected 0", hi); end
    endtask

    initial begin
        start = 1'b0; op = 2'b00; inA = 32'h0; inB = 32'h0;
        hi_wen = 1'b0; lo_wen = 1'b0; wd = 32'h0; reset = 1'b1;
        test_reset();
        test_mt_writes();
        test_reset_mid_op();
        test_arith();
        test_div_by_zero();
        test_hazards();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
